fifo_tx_serializer: RTL and testbench

Downstream consumer of the 16x16 word FIFO. It pops one 16-bit word at a time through the FIFO's `read`/`fifo_out` interface and transmits it on a single-wire asynchronous serial line. Each word is sent as one frame: start bit, 16 data bits MSB first, parity bit, stop bit. The block sits between the FIFO and the board-level serial pin, and its `read` output drives the FIFO `read` input directly.

---
 rtl/fifo_tx_serializer.sv | 114 +++++++++++
 tb/tb_fifo_tx_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
// Pops 16-bit words from the upstream FIFO and sends each as one serial frame:
// start bit, 16 data bits MSB first, parity bit, stop bit, each DIV clocks long.
module fifo_tx_serializer #(
  parameter int DIV        = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_out,
  output logic        read,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  word_count
);

  // FIFO handshake: read is a registered one-cycle pop request, raised only after
  // an edge that saw fifo_empty=0 in IDLE; fifo_out is valid during the following
  // LOAD cycle and is captured on LOAD's closing edge.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [7:0]  wc_q, wc_d;
  logic        read_q, read_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        bit_end;

  assign bit_end = (div_q == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable && !fifo_empty) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && bit_q == 4'd15) state_d = S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d    = 8'd0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    wc_d     = wc_q;
    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
      div_d = bit_end ? 8'd0 : div_q + 8'd1;
    if (state_q == S_LOAD) begin
      shift_d  = fifo_out;
      parity_d = (^fifo_out) ^ PARITY_ODD;
    end
    if (state_q == S_DATA && bit_end) begin
      shift_d = {shift_q[14:0], 1'b0};
      bit_d   = bit_q + 4'd1;
    end
    if (state_q == S_STOP && bit_end) wc_d = wc_q + 8'd1;
    // Outputs are decoded from the next state so the pins come straight from flops.
    read_d = (state_d == S_FETCH);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[15];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q    <= 8'd0;
      bit_q    <= 4'd0;
      shift_q  <= 16'd0;
      parity_q <= 1'b0;
      wc_q     <= 8'd0;
      read_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      wc_q     <= wc_d;
      read_q   <= read_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign read       = read_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Bench for fifo_tx_serializer: two instances (DIV=4 even parity, DIV=1 odd parity),
// each fed by a queue-based FIFO model, with frames checked against a bit-level model.
module tb_fifo_tx_serializer;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en    [2];
  logic        empty [2];
  logic [15:0] fout  [2];
  logic        rd    [2];
  logic        tx    [2];
  logic        busy  [2];
  logic [7:0]  wc    [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int reads [2];
  bit rd_prev [2];
  bit pop_pend [2];
  int req_cyc [2];
  int viol_empty = 0;
  int viol_double = 0;
  logic [7:0]  exp_wc [2];
  logic [15:0] fq0[$];
  logic [15:0] fq1[$];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  always #5 clk = ~clk;

  fifo_tx_serializer #(.DIV(DIV_A), .PARITY_ODD(1'b0)) u_dut_a (
    .clock(clk), .reset(rst), .enable(en[0]), .fifo_empty(empty[0]),
    .fifo_out(fout[0]), .read(rd[0]), .tx(tx[0]), .busy(busy[0]), .word_count(wc[0])
  );

  fifo_tx_serializer #(.DIV(DIV_B), .PARITY_ODD(1'b1)) u_dut_b (
    .clock(clk), .reset(rst), .enable(en[1]), .fifo_empty(empty[1]),
    .fifo_out(fout[1]), .read(rd[1]), .tx(tx[1]), .busy(busy[1]), .word_count(wc[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Frame model: bit slot 0 start, 1..16 data MSB first, 17 parity, 18 stop.
  function automatic logic tx_model(input logic [15:0] w, input bit odd, input int div, input int k);
    int b;
    b = k / div;
    if (b == 0) return 1'b0;
    if (b <= 16) return w[16 - b];
    if (b == 17) return (^w) ^ odd;
    return 1'b1;
  endfunction

  // One clock: FIFO pops on the posedge that sees read=1, DUT sampled on the negedge.
  task automatic tick();
    @(posedge clk);
    if (pop_pend[0]) begin
      if (fq0.size() > 0) fout[0] = fq0.pop_front();
      else viol_empty++;
    end
    if (pop_pend[1]) begin
      if (fq1.size() > 0) fout[1] = fq1.pop_front();
      else viol_empty++;
    end
    empty[0] = (fq0.size() == 0);
    empty[1] = (fq1.size() == 0);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rd[i] === 1'b1) begin
        reads[i]++;
        if (empty[i]) viol_empty++;
        if (rd_prev[i]) viol_double++;
      end
      rd_prev[i]  = (rd[i] === 1'b1);
      pop_pend[i] = (rd[i] === 1'b1);
    end
  endtask

  task automatic push(input int i, input logic [15:0] w);
    if (i == 0) begin
      fq0.push_back(w);
      exp_q0.push_back(w);
    end else begin
      fq1.push_back(w);
      exp_q1.push_back(w);
    end
    empty[i] = 1'b0;
  endtask

  task automatic run_frame(input int i, input int div, input bit odd, input int drop_at,
                           input int abort_at, output logic par, output bit aborted);
    int n;
    logic [15:0] w;
    aborted = 1'b0;
    par = 1'bx;
    w = 16'h0;
    n = 0;
    while (rd[i] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("read_request", rd[i], 1'b1);
    if (rd[i] !== 1'b1) return;
    req_cyc[i] = cyc;
    if (i == 0 && exp_q0.size() > 0) w = exp_q0.pop_front();
    if (i == 1 && exp_q1.size() > 0) w = exp_q1.pop_front();
    chk("busy_fetch", busy[i], 1'b1);
    tick();
    chk("read_one_cycle", rd[i], 1'b0);
    chk("tx_load_idle", tx[i], 1'b1);
    tick();
    for (int k = 0; k < 19 * div; k++) begin
      if (k == drop_at) en[i] = 1'b0;
      if (k == abort_at) begin
        aborted = 1'b1;
        return;
      end
      chk($sformatf("tx_dut%0d_k%0d", i, k), tx[i], tx_model(w, odd, div, k));
      chk("busy_frame", busy[i], 1'b1);
      if (k == 17 * div) par = tx[i];
      tick();
    end
    exp_wc[i] = exp_wc[i] + 8'd1;
    chk("word_count", wc[i], exp_wc[i]);
    chk("busy_end", busy[i], 1'b0);
    chk("tx_end_idle", tx[i], 1'b1);
  endtask

  initial begin
    logic par;
    bit ab;
    int prev_req;
    int rd_snap;
    logic [15:0] w;

    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      empty[i] = 1'b1;
      fout[i] = 16'h0;
      reads[i] = 0;
      rd_prev[i] = 1'b0;
      pop_pend[i] = 1'b0;
      req_cyc[i] = 0;
      exp_wc[i] = 8'd0;
    end
    repeat (3) tick();
    chk("reset_tx", tx[0], 1'b1);
    chk("reset_read", rd[0], 1'b0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_wc", wc[0], 8'd0);
    rst = 1'b0;

    // Enabled but FIFO empty: nothing may move.
    en[0] = 1'b1;
    en[1] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk("idle_tx", tx[i], 1'b1);
        chk("idle_read", rd[i], 1'b0);
        chk("idle_busy", busy[i], 1'b0);
        chk("idle_wc", wc[i], 8'd0);
      end
    end

    // Directed word A5C3 at DIV=4, even parity.
    push(0, 16'hA5C3);
    run_frame(0, DIV_A, 1'b0, -1, -1, par, ab);
    chk("a5c3_parity", par, 1'b0);
    chk("a5c3_latency", cyc - req_cyc[0], 78);

    // 16'h0001: odd-parity build gives 0, even-parity build gives 1.
    push(1, 16'h0001);
    run_frame(1, DIV_B, 1'b1, -1, -1, par, ab);
    chk("odd_parity_0001", par, 1'b0);
    push(0, 16'h0001);
    run_frame(0, DIV_A, 1'b0, -1, -1, par, ab);
    chk("even_parity_0001", par, 1'b1);

    // Three preloaded random words, enable held: back-to-back frames.
    rd_snap = reads[0];
    for (int j = 0; j < 3; j++) push(0, 16'($urandom));
    prev_req = 0;
    for (int j = 0; j < 3; j++) begin
      run_frame(0, DIV_A, 1'b0, -1, -1, par, ab);
      if (j > 0) chk("b2b_period", req_cyc[0] - prev_req, 79);
      prev_req = req_cyc[0];
    end
    chk("b2b_read_pulses", reads[0] - rd_snap, 3);
    chk("b2b_fifo_empty", empty[0], 1'b1);

    // Enable dropped mid-DATA: frame completes, no pop until enable returns.
    push(0, 16'($urandom));
    push(0, 16'($urandom));
    run_frame(0, DIV_A, 1'b0, 5 * DIV_A, -1, par, ab);
    rd_snap = reads[0];
    repeat (40) tick();
    chk("no_read_while_disabled", reads[0] - rd_snap, 0);
    chk("busy_while_disabled", busy[0], 1'b0);
    en[0] = 1'b1;
    run_frame(0, DIV_A, 1'b0, -1, -1, par, ab);

    // Asynchronous reset in the middle of DATA.
    push(0, 16'($urandom));
    run_frame(0, DIV_A, 1'b0, -1, $urandom_range(DIV_A * 1, DIV_A * 17 - 1), par, ab);
    chk("abort_reached", ab, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", tx[0], 1'b1);
    chk("async_rst_busy", busy[0], 1'b0);
    chk("async_rst_read", rd[0], 1'b0);
    chk("async_rst_wc", wc[0], 8'd0);
    exp_wc[0] = 8'd0;
    exp_wc[1] = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle_busy", busy[0], 1'b0);
    push(0, 16'($urandom));
    rd_snap = reads[0];
    run_frame(0, DIV_A, 1'b0, -1, -1, par, ab);
    chk("post_rst_fresh_pop", reads[0] - rd_snap, 1);

    // word_count wrap on the DIV=1 instance: 256 frames bring it back to 0.
    en[0] = 1'b0;
    for (int j = 0; j < 256; j++) begin
      w = 16'($urandom);
      push(1, w);
      run_frame(1, DIV_B, 1'b1, -1, -1, par, ab);
    end
    chk("wc_wrap", wc[1], 8'd0);

    repeat (5) tick();
    chk("no_read_when_empty", viol_empty, 0);
    chk("no_double_read", viol_double, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
